// File: rtl/smart_home_pkg.sv
// Shared constants and types for the smart-home sensor front end.
//   TEMP_W / FRAME_W : temperature reading width and serial frame width
//   frame_state_e    : serial-frame deserialiser states
//   ST_RESET_DEFAULT : temperature reading presented after reset
package smart_home_pkg;

    localparam int unsigned TEMP_W  = 7;
    localparam int unsigned FRAME_W = 8;

    localparam logic [TEMP_W-1:0] ST_RESET_DEFAULT = 7'd25;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } frame_state_e;

    // Even parity over the whole frame: data bits plus parity bit.
    function automatic logic parity_ok(input logic [FRAME_W-1:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debouncer for one
// contact input.
//   clk, rst : clock and synchronous active-high reset
//   raw      : asynchronous contact level
//   clean    : registered debounced level
// With FAST_ASSERT set, a synchronised 1 drives the output high immediately;
// the falling edge still needs the full debounce run.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          FAST_ASSERT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync_q;
    logic       out_q;
    logic       out_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count consecutive mismatching cycles; any agreement clears the run.
    // The count never passes CntLast, so the 8-bit counter cannot wrap.
    always_comb begin
        out_d = out_q;
        cnt_d = 8'd0;
        if (sync_q != out_q) begin
            if (FAST_ASSERT && sync_q) begin
                out_d = 1'b1;
            end else if (cnt_q == CntLast) begin
                out_d = sync_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean = out_q;

endmodule

// File: rtl/smart_home_sensor_frontend.sv
// Sensor-side front end of the smart-home controller.
//   Clk, Rst                       : clock and synchronous active-high reset
//   raw_fd, raw_rd, raw_w, raw_fa  : asynchronous door/window/fire contacts
//   ts_valid, ts_bit, ts_start     : serial temperature bit strobe, data, frame start
//   SFD, SRD, SW, SFA              : debounced contacts (SFA asserts without debounce)
//   ST                             : last good 7-bit temperature reading
//   st_update                      : one-cycle pulse when ST loads
//   temp_err                       : one-cycle pulse on parity or inter-bit timeout
// Frames are 8 bits MSB first (data 6..0, then even parity). All outputs are registered.
module smart_home_sensor_frontend
    import smart_home_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = 4,
    parameter int unsigned       TIMEOUT_CYCLES  = 64,
    parameter logic [TEMP_W-1:0] ST_RESET        = ST_RESET_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              raw_fd,
    input  logic              raw_rd,
    input  logic              raw_w,
    input  logic              raw_fa,
    input  logic              ts_valid,
    input  logic              ts_bit,
    input  logic              ts_start,
    output logic              SFD,
    output logic              SRD,
    output logic              SW,
    output logic              SFA,
    output logic [TEMP_W-1:0] ST,
    output logic              st_update,
    output logic              temp_err
);

    localparam logic [3:0] LastBit  = 4'(FRAME_W - 1);
    localparam logic [9:0] IdleLast = 10'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Contacts
    // ------------------------------------------------------------------
    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .FAST_ASSERT     (1'b0)
    ) u_db_fd (
        .clk   (Clk),
        .rst   (Rst),
        .raw   (raw_fd),
        .clean (SFD)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .FAST_ASSERT     (1'b0)
    ) u_db_rd (
        .clk   (Clk),
        .rst   (Rst),
        .raw   (raw_rd),
        .clean (SRD)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .FAST_ASSERT     (1'b0)
    ) u_db_w (
        .clk   (Clk),
        .rst   (Rst),
        .raw   (raw_w),
        .clean (SW)
    );

    // Fire alarm is fail-safe: it raises immediately, clears only when debounced.
    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .FAST_ASSERT     (1'b1)
    ) u_db_fa (
        .clk   (Clk),
        .rst   (Rst),
        .raw   (raw_fa),
        .clean (SFA)
    );

    // ------------------------------------------------------------------
    // Temperature frame deserialiser
    // ------------------------------------------------------------------
    frame_state_e      state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [9:0]         idle_q, idle_d;
    logic [TEMP_W-1:0]  st_q, st_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        idle_d    = idle_q;
        st_d      = st_q;
        upd_d     = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                idle_d = 10'd0;
                if (ts_valid && ts_start) begin
                    frame_d   = {{(FRAME_W-1){1'b0}}, ts_bit};
                    bit_cnt_d = 4'd1;
                    state_d   = StShift;
                end
            end

            StShift: begin
                if (ts_valid) begin
                    idle_d = 10'd0;
                    if (ts_start) begin
                        // Resynchronise on a new start: drop the partial frame silently.
                        frame_d   = {{(FRAME_W-1){1'b0}}, ts_bit};
                        bit_cnt_d = 4'd1;
                    end else begin
                        frame_d   = {frame_q[FRAME_W-2:0], ts_bit};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LastBit) begin
                            state_d = StCheck;
                        end
                    end
                end else if (idle_q == IdleLast) begin
                    err_d     = 1'b1;
                    idle_d    = 10'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = StIdle;
                end else begin
                    idle_d = idle_q + 10'd1;
                end
            end

            StCheck: begin
                // Inputs are ignored here; a start bit arriving now is lost.
                if (parity_ok(frame_q)) begin
                    st_d  = frame_q[FRAME_W-1:1];
                    upd_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                bit_cnt_d = 4'd0;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            frame_q   <= '0;
            bit_cnt_q <= 4'd0;
            idle_q    <= 10'd0;
            st_q      <= ST_RESET;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            st_q      <= st_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
        end
    end

    assign ST        = st_q;
    assign st_update = upd_q;
    assign temp_err  = err_q;

endmodule

// File: tb/tb_smart_home_sensor_frontend.sv
// Self-checking bench for smart_home_sensor_frontend: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_smart_home_sensor_frontend;

    localparam int unsigned DB     = 4;
    localparam int unsigned TO     = 64;
    localparam logic [6:0]  ST_RST = 7'd25;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       raw_fd, raw_rd, raw_w, raw_fa;
    logic       ts_valid, ts_bit, ts_start;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       st_update, temp_err;

    always #5 Clk = ~Clk;

    smart_home_sensor_frontend #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO),
        .ST_RESET        (ST_RST)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .raw_fd    (raw_fd),
        .raw_rd    (raw_rd),
        .raw_w     (raw_w),
        .raw_fa    (raw_fa),
        .ts_valid  (ts_valid),
        .ts_bit    (ts_bit),
        .ts_start  (ts_start),
        .SFD       (SFD),
        .SRD       (SRD),
        .SW        (SW),
        .SFA       (SFA),
        .ST        (ST),
        .st_update (st_update),
        .temp_err  (temp_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          rand_contacts = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: contacts are a 2-cycle delay followed by "output takes
    // the new level once the last DB samples since the previous change all
    // disagree with it"; frames are collected as a bit list and judged by
    // counting ones.
    // ------------------------------------------------------------------
    bit          m_d1[4];
    bit          m_d2[4];
    bit          m_out[4];
    logic [DB-1:0] m_win[4];
    int          m_fill[4];
    logic [6:0]  m_st;
    bit          m_upd, m_err, m_in_frame, m_check;
    bit          m_bits[$];
    int          m_gap;

    task automatic model_edge();
        bit          raw[4];
        bit          s;
        int          ones;
        int unsigned val;
        raw[0] = raw_fd;
        raw[1] = raw_rd;
        raw[2] = raw_w;
        raw[3] = raw_fa;
        if (Rst) begin
            for (int c = 0; c < 4; c++) begin
                m_d1[c] = 0; m_d2[c] = 0; m_out[c] = 0; m_win[c] = '0; m_fill[c] = 0;
            end
            m_st = ST_RST; m_upd = 0; m_err = 0; m_in_frame = 0; m_check = 0;
            m_bits.delete();
            m_gap = 0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            s = m_d2[c];
            m_d2[c] = m_d1[c];
            m_d1[c] = raw[c];
            if (c == 3 && s && !m_out[c]) begin
                m_out[c] = 1;
                m_fill[c] = 0;
            end else begin
                m_win[c] = {m_win[c][DB-2:0], s};
                m_fill[c]++;
                if (m_fill[c] >= DB && m_win[c] == {DB{~m_out[c]}}) begin
                    m_out[c] = s;
                    m_fill[c] = 0;
                end
            end
        end
        m_upd = 0;
        m_err = 0;
        if (m_check) begin
            ones = 0;
            val = 0;
            foreach (m_bits[i]) ones += int'(m_bits[i]);
            for (int i = 0; i < 7; i++) val = val * 2 + int'(m_bits[i]);
            if (ones % 2 == 0) begin
                m_st = 7'(val);
                m_upd = 1;
            end else begin
                m_err = 1;
            end
            m_check = 0;
            m_in_frame = 0;
            m_bits.delete();
        end else if (m_in_frame) begin
            if (ts_valid) begin
                m_gap = 0;
                if (ts_start) m_bits.delete();
                m_bits.push_back(ts_bit);
                if (m_bits.size() == 8) m_check = 1;
            end else begin
                m_gap++;
                if (m_gap == TO) begin
                    m_err = 1;
                    m_in_frame = 0;
                    m_bits.delete();
                end
            end
        end else if (ts_valid && ts_start) begin
            m_bits.delete();
            m_bits.push_back(ts_bit);
            m_in_frame = 1;
            m_gap = 0;
        end
    endtask

    // Inputs are changed only at the falling edge; outputs compared there too.
    task automatic step();
        if (rand_contacts) begin
            if ($urandom_range(5, 0) == 0) raw_fd = ~raw_fd;
            if ($urandom_range(5, 0) == 0) raw_rd = ~raw_rd;
            if ($urandom_range(5, 0) == 0) raw_w  = ~raw_w;
            if ($urandom_range(7, 0) == 0) raw_fa = ~raw_fa;
        end
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("SFD", SFD, m_out[0]);
        check("SRD", SRD, m_out[1]);
        check("SW", SW, m_out[2]);
        check("SFA", SFA, m_out[3]);
        check("ST", ST, m_st);
        check("st_update", st_update, m_upd);
        check("temp_err", temp_err, m_err);
    endtask

    task automatic send_bit(input bit b, input bit st, input int unsigned gap);
        for (int i = 0; i < int'(gap); i++) begin
            ts_valid = 0; ts_start = 0; ts_bit = 1'($urandom);
            step();
        end
        ts_valid = 1; ts_bit = b; ts_start = st;
        step();
        ts_valid = 0; ts_start = 0;
    endtask

    task automatic send_frame(input logic [6:0] data, input bit par, input int unsigned gap_max);
        for (int i = 6; i >= 0; i--) begin
            send_bit(data[i], (i == 6), (i == 6) ? 0 : $urandom_range(gap_max, 0));
        end
        send_bit(par, 1'b0, $urandom_range(gap_max, 0));
    endtask

    logic [6:0] v;

    initial begin
        Rst = 1; raw_fd = 0; raw_rd = 0; raw_w = 0; raw_fa = 0;
        ts_valid = 0; ts_bit = 0; ts_start = 0;
        repeat (3) step();
        Rst = 0;
        check("reset_ST", ST, 7'd25);
        check("reset_SFD", SFD, 0);
        repeat (100) step();
        check("idle_ST", ST, 7'd25);

        // Front door: debounced rise exactly 6 edges after the pin changes.
        raw_fd = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) check("fd_not_yet", SFD, 0);
            if (k == 6) check("fd_rise", SFD, 1);
        end
        // Window glitch of 3 cycles is filtered.
        raw_w = 1;
        repeat (3) step();
        raw_w = 0;
        repeat (10) step();
        check("w_glitch", SW, 0);
        // Fire alarm 1-cycle pulse: fast rise, debounced fall.
        raw_fa = 1;
        for (int k = 1; k <= 9; k++) begin
            step();
            raw_fa = 0;
            if (k == 2) check("fa_before", SFA, 0);
            if (k == 3) check("fa_rise", SFA, 1);
            if (k == 6) check("fa_hold", SFA, 1);
            if (k == 7) check("fa_fall", SFA, 0);
        end

        // Good frame of 28, back to back, then the same with bad parity.
        v = 7'd28;
        send_frame(v, ^v, 0);
        step();
        check("good_ST", ST, 7'd28);
        check("good_upd", st_update, 1);
        check("good_err", temp_err, 0);
        step();
        send_frame(v, ~^v, 0);
        step();
        check("bad_err", temp_err, 1);
        check("bad_upd", st_update, 0);
        check("bad_ST", ST, 7'd28);
        step();

        // Timeout after 3 bits.
        send_bit(1, 1, 0); send_bit(0, 0, 0); send_bit(1, 0, 0);
        for (int k = 1; k <= TO; k++) begin
            step();
            if (k == TO - 1) check("to_early", temp_err, 0);
            if (k == TO) check("to_err", temp_err, 1);
        end
        check("to_ST", ST, 7'd28);
        step();
        // Mid-frame restart: 4 bits, then a complete frame from a new start.
        send_bit(0, 1, 0); send_bit(1, 0, 0); send_bit(1, 0, 1); send_bit(0, 0, 0);
        v = 7'd55;
        send_frame(v, ^v, 0);
        step();
        check("resync_ST", ST, 7'd55);
        check("resync_upd", st_update, 1);
        step();

        // Reset during bit 5.
        send_bit(0, 1, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0);
        ts_valid = 1; ts_bit = 1; Rst = 1;
        step();
        ts_valid = 0;
        step();
        Rst = 0;
        check("rst_ST", ST, 7'd25);
        check("rst_upd", st_update, 0);
        check("rst_err", temp_err, 0);
        repeat (5) step();
        v = 7'd18;
        send_frame(v, ^v, 0);
        step();
        check("after_rst_ST", ST, 7'd18);
        step();

        // Randomized phase.
        rand_contacts = 1;
        for (int f = 0; f < 80; f++) begin
            int unsigned kind;
            int unsigned n;
            repeat ($urandom_range(6, 1)) begin
                ts_valid = 1'($urandom); ts_start = 0; ts_bit = 1'($urandom);
                step();
            end
            ts_valid = 0;
            kind = $urandom_range(9, 0);
            v = 7'($urandom);
            if (kind < 6) begin
                send_frame(v, ($urandom_range(3, 0) == 0) ? ~^v : ^v, 2);
                step();
            end else if (kind == 6) begin
                n = $urandom_range(7, 1);
                for (int i = 0; i < int'(n); i++) send_bit(1'($urandom), (i == 0), 0);
                repeat (TO + 3) step();
            end else if (kind < 9) begin
                n = $urandom_range(6, 1);
                for (int i = 0; i < int'(n); i++) send_bit(1'($urandom), (i == 0), 1);
                send_frame(v, ^v, 1);
                step();
            end else begin
                send_bit(1'($urandom), 1, 0);
                Rst = 1;
                step();
                Rst = 0;
            end
        end
        rand_contacts = 0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
